four_bit_sync_counter: RTL and testbench



---
 rtl/four_bit_sync_counter_pkg.sv | 18 +
 rtl/four_bit_sync_counter_if.sv | 29 ++
 rtl/four_bit_sync_counter_tff.sv | 35 +++
 rtl/four_bit_sync_counter.sv | 65 ++++++
 tb/tb_four_bit_sync_counter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/four_bit_sync_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : four_bit_sync_counter_pkg
// Purpose  : Shared width, limit and reset constants and the count type for
//            the four-bit synchronous counter slice.
// Revision : 1.0 - initial release
// ============================================================================
package four_bit_sync_counter_pkg;

   localparam int CNT_W = 4;

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t CNT_MAX = 4'hF;
   localparam cnt_t CNT_RST = 4'h0;

endpackage : four_bit_sync_counter_pkg
`default_nettype wire

// File: rtl/four_bit_sync_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : four_bit_sync_counter_if
// Purpose  : Bundles the enable / count / carry signals of one counter slice.
//            The master drives the enable and observes the count; the slave
//            is the counter itself.
// Revision : 1.0 - initial release
// ============================================================================
interface four_bit_sync_counter_if;
   import four_bit_sync_counter_pkg::*;

   logic cnt_en;
   cnt_t count;
   logic carry;

   modport master (
      output cnt_en,
      input  count,
      input  carry
   );

   modport slave (
      input  cnt_en,
      output count,
      output carry
   );

endinterface : four_bit_sync_counter_if
`default_nettype wire

// File: rtl/four_bit_sync_counter_tff.sv
`default_nettype none
// ============================================================================
// Module   : sync_counter_tff
// Purpose  : One toggle flip-flop stage of the counter. Toggles on the rising
//            clock edge while t is high; cleared asynchronously by rstn.
// Revision : 1.0 - initial release
// ============================================================================
module sync_counter_tff (
   input  wire logic clk,
   input  wire logic rstn,
   input  wire logic t,
   output logic      q
);

   logic q_q;
   logic q_d;

   // Next state: invert the stored bit when the stage enable is high
   always_comb begin
      q_d = q_q ^ t;
   end

   // State register with asynchronous active-low clear
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule : sync_counter_tff
`default_nettype wire

// File: rtl/four_bit_sync_counter.sv
`default_nettype none
// ============================================================================
// Module   : four_bit_sync_counter
// Purpose  : Four-bit synchronous binary up-counter with count enable and a
//            combinational ripple-carry output for cascading slices.
//            Every bit is a toggle stage on the shared clock; stage i toggles
//            when cnt_en and all lower bits are high (74x161 style).
// Config   : FOUR_BIT_SYNC_COUNTER_SVA_EN - compiles in concurrent assertions
//            on counting, holding, carry, reset and X-freedom. Logic is the
//            same whether or not it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module four_bit_sync_counter
   import four_bit_sync_counter_pkg::*;
(
   input  wire logic rstn,
   input  wire logic clk,
   input  wire logic cnt_en,
   output cnt_t      count,
   output logic      carry
);

   // w_en[i] is the toggle enable of stage i; w_en[CNT_W] is the enable a
   // fifth stage would see, i.e. cnt_en with every count bit high.
   logic [CNT_W:0] w_en;

   assign w_en[0] = cnt_en;

   generate
      for (genvar gi = 0; gi < CNT_W; gi++) begin : g_stage
         sync_counter_tff u_tff (
            .clk  (clk),
            .rstn (rstn),
            .t    (w_en[gi]),
            .q    (count[gi])
         );

         assign w_en[gi+1] = w_en[gi] & count[gi];
      end
   endgenerate

   // Terminal-count carry: end of the enable chain, purely combinational so
   // it drops with cnt_en and lets the next slice count on the wrap edge.
   assign carry = w_en[CNT_W];

`ifdef FOUR_BIT_SYNC_COUNTER_SVA_EN
   // Reset release is expected to be synchronised to clk upstream.
   a_count_inc : assert property (@(posedge clk) disable iff (!rstn)
      cnt_en |=> (count == cnt_t'($past(count) + 1'b1)));

   a_count_hold : assert property (@(posedge clk) disable iff (!rstn)
      !cnt_en |=> $stable(count));

   a_carry : assert property (@(posedge clk)
      carry == (cnt_en && (count == CNT_MAX)));

   a_reset_val : assert property (@(posedge clk)
      !rstn |-> (count == CNT_RST));

   a_no_x : assert property (@(posedge clk) disable iff (!rstn)
      !$isunknown({count, carry}));
`endif

endmodule : four_bit_sync_counter
`default_nettype wire

// File: tb/tb_four_bit_sync_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_four_bit_sync_counter
// Purpose  : Self-checking bench for four_bit_sync_counter. Directed stimulus
//            pushes hand-computed expectations into a scoreboard queue; a
//            separate monitor pops and compares on each sample event.
// Revision : 1.0 - initial release
// ============================================================================
module tb_four_bit_sync_counter;
   import four_bit_sync_counter_pkg::*;

   typedef struct {
      string      name;
      bit         sel;     // 0: single slice, 1: cascaded pair
      logic [9:0] exp;
   } exp_t;

   logic clk      = 1'b0;
   logic rstn     = 1'b0;
   logic cas_rstn = 1'b0;
   logic cas_en   = 1'b0;

   four_bit_sync_counter_if cnt_if ();

   cnt_t lo_count;
   cnt_t hi_count;
   logic lo_carry;
   logic hi_carry;

   exp_t sb_q[$];
   event sample_ev;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   four_bit_sync_counter dut (
      .rstn   (rstn),
      .clk    (clk),
      .cnt_en (cnt_if.cnt_en),
      .count  (cnt_if.count),
      .carry  (cnt_if.carry)
   );

   four_bit_sync_counter u_cas_lo (
      .rstn   (cas_rstn),
      .clk    (clk),
      .cnt_en (cas_en),
      .count  (lo_count),
      .carry  (lo_carry)
   );

   four_bit_sync_counter u_cas_hi (
      .rstn   (cas_rstn),
      .clk    (clk),
      .cnt_en (lo_carry),
      .count  (hi_count),
      .carry  (hi_carry)
   );

   // Monitor: drain every pending expectation when a sample is signalled
   initial begin
      exp_t       e;
      logic [9:0] got;
      forever begin
         @(sample_ev);
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.sel)
               got = {hi_carry, lo_carry, hi_count, lo_count};
            else
               got = {5'b0, cnt_if.carry, cnt_if.count};
            checks++;
            if (got !== e.exp) begin
               failures++;
               $display("FAIL %s: got=%h expected=%h", e.name, got, e.exp);
            end
         end
      end
   end

   task automatic push(input string name, input bit sel, input logic [9:0] exp);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.exp  = exp;
      sb_q.push_back(e);
      ->sample_ev;
      #1;
   endtask

   task automatic chk_main(input string name, input int c, input bit cy);
      cnt_t cv;
      cv = cnt_t'(c);
      push(name, 1'b0, {5'b0, cy, cv});
   endtask

   task automatic chk_cas(input string name, input int v);
      cnt_t lo;
      cnt_t hi;
      lo = cnt_t'(v % 16);
      hi = cnt_t'(v / 16);
      push(name, 1'b1, {1'b0, (lo == 4'hF), hi, lo});
   endtask

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus
   initial begin
      cnt_if.cnt_en = 1'b0;

      // Reset held with clock running
      #2;
      chk_main("reset_t2", 0, 1'b0);
      @(posedge clk);
      #2;
      chk_main("reset_after_edge", 0, 1'b0);

      // Free run: release and enable on the falling edge at t=10
      @(negedge clk);
      rstn          = 1'b1;
      cnt_if.cnt_en = 1'b1;
      for (int k = 1; k <= 22; k++) begin
         @(negedge clk);
         chk_main("free_run", k % 16, (k % 16) == 15);
      end

      // Hold at 6 for three edges
      cnt_if.cnt_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk_main("hold", 6, 1'b0);
      end
      cnt_if.cnt_en = 1'b1;
      @(negedge clk);
      chk_main("hold_resume", 7, 1'b0);

      // Count up to 15
      for (int v = 8; v <= 15; v++) begin
         @(negedge clk);
         chk_main("to_max", v, v == 15);
      end

      // Carry gating without a clock edge
      cnt_if.cnt_en = 1'b0;
      #1;
      chk_main("carry_drop", 15, 1'b0);
      @(negedge clk);
      chk_main("carry_hold_15", 15, 1'b0);
      cnt_if.cnt_en = 1'b1;
      #1;
      chk_main("carry_rise", 15, 1'b1);
      @(negedge clk);
      chk_main("wrap_after_gate", 0, 1'b0);

      // Count to 9 then reset asynchronously between edges
      for (int v = 1; v <= 9; v++) begin
         @(negedge clk);
         chk_main("to_nine", v, 1'b0);
      end
      rstn = 1'b0;
      #1;
      chk_main("async_reset", 0, 1'b0);
      rstn = 1'b1;
      @(negedge clk);
      chk_main("after_reset", 1, 1'b0);

      // Cascade of two slices for 40 edges
      @(negedge clk);
      cas_rstn = 1'b1;
      cas_en   = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         chk_cas("cascade", k);
      end

      // Every expectation must have been consumed
      #2;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got=%0d pending expected=0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_four_bit_sync_counter
`default_nettype wire
